// File: rtl/alu_arb_pkg.sv
// Shared types for the two-requester ALU arbiter: FSM state encoding,
// requester ids and the latched-operation record.
package alu_arb_pkg;

    localparam int DATA_W = 8;
    localparam int SEL_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } arb_state_t;

    typedef logic req_id_t;

    localparam req_id_t REQ0 = 1'b0;
    localparam req_id_t REQ1 = 1'b1;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              cin;
        logic [SEL_W-1:0]  sel;
    } alu_op_t;

    function automatic logic [1:0] id_to_onehot(input req_id_t id);
        return (id == REQ1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/alu.sv
// 8-bit ALU: S[3:2] picks arithmetic / logic / shift / move, S[1:0] the variant.
// Arithmetic ripples a carry bit by bit; z flags an all-zero result.
module alu
    import alu_arb_pkg::*;
(
    output logic [DATA_W-1:0] D,
    output logic              C_out,
    output logic              z,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic              C_in,
    input  logic [SEL_W-1:0]  S
);

    logic [DATA_W-1:0] b_eff;
    logic [DATA_W-1:0] sum;
    logic              add_c;
    logic [DATA_W-1:0] logic_d;
    logic [DATA_W-1:0] shift_d;
    logic              shift_c;
    logic [DATA_W-1:0] move_d;

    // Second adder operand: B, ~B (subtract), 0 (increment), all-ones (decrement).
    always_comb begin
        b_eff = B;
        case (S[1:0])
            2'b00:   b_eff = B;
            2'b01:   b_eff = ~B;
            2'b10:   b_eff = '0;
            default: b_eff = '1;
        endcase
    end

    always_comb begin : ripple
        logic c;
        sum = '0;
        c   = C_in;
        // NOTE: blocking assignments are required here; the carry must ripple
        // through each bit within a single evaluation of this block.
        for (int i = 0; i < DATA_W; i++) begin
            sum[i] = A[i] ^ b_eff[i] ^ c;
            c      = (A[i] & b_eff[i]) | (c & (A[i] ^ b_eff[i]));
        end
        add_c = c;
    end

    always_comb begin
        logic_d = '0;
        case (S[1:0])
            2'b00:   logic_d = A & B;
            2'b01:   logic_d = A | B;
            2'b10:   logic_d = A ^ B;
            default: logic_d = ~A;
        endcase
    end

    // Shifts and rotates; C_in feeds the vacated bit of plain shifts.
    always_comb begin
        shift_d = '0;
        shift_c = 1'b0;
        case (S[1:0])
            2'b00: begin
                shift_d = {A[DATA_W-2:0], C_in};
                shift_c = A[DATA_W-1];
            end
            2'b01: begin
                shift_d = {C_in, A[DATA_W-1:1]};
                shift_c = A[0];
            end
            2'b10: begin
                shift_d = {A[DATA_W-2:0], A[DATA_W-1]};
                shift_c = A[DATA_W-1];
            end
            default: begin
                shift_d = {A[0], A[DATA_W-1:1]};
                shift_c = A[0];
            end
        endcase
    end

    always_comb begin
        move_d = '0;
        case (S[1:0])
            2'b00:   move_d = A;
            2'b01:   move_d = B;
            2'b10:   move_d = {A[3:0], A[7:4]};
            default: move_d = '0;
        endcase
    end

    always_comb begin
        D     = '0;
        C_out = 1'b0;
        case (S[3:2])
            2'b00: begin
                D     = sum;
                C_out = add_c;
            end
            2'b01:   D = logic_d;
            2'b10: begin
                D     = shift_d;
                C_out = shift_c;
            end
            default: D = move_d;
        endcase
    end

    assign z = ~|D;

endmodule

// File: rtl/alu_arb_rr.sv
// Two-input round-robin picker: a lone valid wins outright; on a tie the
// requester not granted last time wins.
module alu_arb_rr
    import alu_arb_pkg::*;
(
    input  logic       valid0,
    input  logic       valid1,
    input  req_id_t    last_grant,
    output logic [1:0] grant,
    output req_id_t    winner
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        grant  = 2'b00;
        winner = REQ0;
        if (valid0 && valid1) begin
            winner = (last_grant == REQ0) ? REQ1 : REQ0;
        end else if (valid1) begin
            winner = REQ1;
        end
        if (valid0 || valid1) begin
            grant = id_to_onehot(winner);
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two valid/ready requesters: IDLE -> EXEC -> RESP.
// Optional per-requester completion counters under `define ALU_ARB_STATS_EN.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic              req1_valid,
    output logic              req0_ready,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic              req0_cin,
    input  logic              req1_cin,
    input  logic [SEL_W-1:0]  req0_sel,
    input  logic [SEL_W-1:0]  req1_sel,
    output logic              rsp0_valid,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp_d,
    output logic              rsp_cout,
    output logic              rsp_z,
    output logic              busy,
    output logic [CNT_W-1:0]  op_cnt0,
    output logic [CNT_W-1:0]  op_cnt1
);

    arb_state_t        state;
    req_id_t           last_grant;
    req_id_t           cur_id;
    alu_op_t           op_q;
    alu_op_t           win_op;
    logic [1:0]        grant;
    req_id_t           winner;
    logic              xfer;
    logic [DATA_W-1:0] alu_d;
    logic              alu_cout;
    logic              alu_z;

    alu_arb_rr u_rr (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .winner     (winner)
    );

    // Ready is offered only while idle, and only to the arbitration winner.
    assign req0_ready = (state == ST_IDLE) && grant[0];
    assign req1_ready = (state == ST_IDLE) && grant[1];
    assign xfer       = (req0_ready && req0_valid) || (req1_ready && req1_valid);

    assign win_op = (winner == REQ1) ? {req1_a, req1_b, req1_cin, req1_sel}
                                     : {req0_a, req0_b, req0_cin, req0_sel};

    alu u_alu (alu_d, alu_cout, alu_z, op_q.a, op_q.b, op_q.cin, op_q.sel);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            last_grant <= REQ1;
            cur_id     <= REQ0;
            // NOTE: the operand register is reset as well, so the ALU never
            // sees unknown inputs even though its result is not used in IDLE.
            op_q       <= '0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp_d      <= '0;
            rsp_cout   <= 1'b0;
            rsp_z      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (xfer) begin
                        op_q       <= win_op;
                        cur_id     <= winner;
                        last_grant <= winner;
                        busy       <= 1'b1;
                        state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // ALU has had the whole cycle to settle on op_q.
                    rsp_d      <= alu_d;
                    rsp_cout   <= alu_cout;
                    rsp_z      <= alu_z;
                    rsp0_valid <= (cur_id == REQ0);
                    rsp1_valid <= (cur_id == REQ1);
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [CNT_W-1:0] cnt0_q;
    logic [CNT_W-1:0] cnt1_q;

    // Saturating completion counters, bumped as the RESP cycle closes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (state == ST_RESP) begin
            if (cur_id == REQ0 && cnt0_q != {CNT_W{1'b1}}) begin
                cnt0_q <= cnt0_q + CNT_W'(1);
            end
            if (cur_id == REQ1 && cnt1_q != {CNT_W{1'b1}}) begin
                cnt1_q <= cnt1_q + CNT_W'(1);
            end
        end
    end

    assign op_cnt0 = cnt0_q;
    assign op_cnt1 = cnt1_q;
`else
    assign op_cnt0 = '0;
    assign op_cnt1 = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, multi-cycle
// corner sequences and a randomized run against a timing/arithmetic model.
module tb_alu_arbiter;

`ifdef ALU_ARB_STATS_EN
    localparam int TB_CNT_W = 2;
    localparam bit STATS    = 1'b1;
`else
    localparam int TB_CNT_W = 16;
    localparam bit STATS    = 1'b0;
`endif

    logic                clk;
    logic                rst_n;
    logic                req0_valid, req1_valid;
    logic                req0_ready, req1_ready;
    logic [7:0]          req0_a, req0_b, req1_a, req1_b;
    logic                req0_cin, req1_cin;
    logic [3:0]          req0_sel, req1_sel;
    logic                rsp0_valid, rsp1_valid;
    logic [7:0]          rsp_d;
    logic                rsp_cout, rsp_z, busy;
    logic [TB_CNT_W-1:0] op_cnt0, op_cnt1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rsp_cyc  = 0;

    alu_arbiter #(.CNT_W(TB_CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req0_cin   (req0_cin),
        .req1_cin   (req1_cin),
        .req0_sel   (req0_sel),
        .req1_sel   (req1_sel),
        .rsp0_valid (rsp0_valid),
        .rsp1_valid (rsp1_valid),
        .rsp_d      (rsp_d),
        .rsp_cout   (rsp_cout),
        .rsp_z      (rsp_z),
        .busy       (busy),
        .op_cnt0    (op_cnt0),
        .op_cnt1    (op_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference ALU written as plain integer arithmetic; returns {cout, z, d}.
    function automatic logic [9:0] model_alu(input logic [7:0] a, input logic [7:0] b,
                                             input logic cin, input logic [3:0] s);
        int ai, bi, ci, r;
        logic co;
        logic [7:0] d;
        ai = int'(a); bi = int'(b); ci = int'(cin);
        r  = 0; co = 1'b0;
        case (s)
            4'b0000: r = ai + bi + ci;
            4'b0001: r = ai + (255 - bi) + ci;
            4'b0010: r = ai + ci;
            4'b0011: r = ai + 255 + ci;
            4'b0100: r = int'(a & b);
            4'b0101: r = int'(a | b);
            4'b0110: r = int'(a ^ b);
            4'b0111: r = 255 - ai;
            4'b1000: begin r = (ai * 2 + ci) % 256;       co = (ai >= 128);    end
            4'b1001: begin r = ai / 2 + ci * 128;         co = (ai % 2 == 1);  end
            4'b1010: begin r = (ai * 2) % 256 + ai / 128; co = (ai >= 128);    end
            4'b1011: begin r = ai / 2 + (ai % 2) * 128;   co = (ai % 2 == 1);  end
            4'b1100: r = ai;
            4'b1101: r = bi;
            4'b1110: r = (ai % 16) * 16 + ai / 16;
            default: r = 0;
        endcase
        if (s[3:2] == 2'b00) co = (r > 255);
        d = r[7:0];
        return {co, (d == 8'h00), d};
    endfunction

    function automatic int exp_cnt(input int n);
        int max_v;
        max_v = (1 << TB_CNT_W) - 1;
        if (!STATS) return 0;
        return (n > max_v) ? max_v : n;
    endfunction

    task automatic next_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic next_sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic set_req(input logic id, input logic [7:0] a, input logic [7:0] b,
                           input logic cin, input logic [3:0] sel);
        if (id == 1'b0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin; req0_sel = sel;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin; req1_sel = sel;
        end
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_ready"},  32'({req1_ready, req0_ready}), 32'(0));
        check({tag, "_rspv"},   32'({rsp1_valid, rsp0_valid}), 32'(0));
        check({tag, "_rsp"},    32'({rsp_cout, rsp_z, rsp_d}), 32'(0));
        check({tag, "_busy"},   32'(busy), 32'(0));
        check({tag, "_cnt"},    32'({op_cnt1, op_cnt0}), 32'(0));
    endtask

    task automatic apply_reset();
        next_drive();
        rst_n = 1'b0;
        idle_inputs();
        next_sample();
        check_reset_outs("reset");
        next_drive();
        rst_n = 1'b1;
    endtask

    // One isolated operation: transfer in T, response pulse in T+2.
    task automatic do_op(input string tag, input logic id, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic [3:0] sel, input logic [9:0] exp);
        next_drive();
        set_req(id, a, b, cin, sel);
        next_sample();
        check({tag, "_ready"}, 32'({req1_ready, req0_ready}), 32'(id ? 2'b10 : 2'b01));
        check({tag, "_busy_idle"}, 32'(busy), 32'(0));
        next_drive();
        idle_inputs();
        next_sample();
        check({tag, "_exec"}, 32'({busy, rsp1_valid, rsp0_valid}), 32'(3'b100));
        next_drive();
        next_sample();
        check({tag, "_rspv"}, 32'({rsp1_valid, rsp0_valid}), 32'(id ? 2'b10 : 2'b01));
        check({tag, "_data"}, 32'({rsp_cout, rsp_z, rsp_d}), 32'(exp));
        rsp_cyc = cyc;
    endtask

    typedef struct {
        logic       id;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [3:0] sel;
        logic [7:0] d;
        logic       cout;
        logic       z;
    } vec_t;

    vec_t vecs [15];

    // Random-phase model state.
    bit         pend [2];
    logic [7:0] pa [2];
    logic [7:0] pb [2];
    logic       pc [2];
    logic [3:0] ps [2];
    int         served [2];

    initial begin
        logic [9:0] m0, m1, exp_v, rsp_exp;
        logic       last_w, ew, do_x, rsp_id, due;
        logic [9:0] last_rsp;
        int         prev_cyc, free_at, xfer_at, rsp_due;

        vecs[0]  = '{1'b0, 8'h51, 8'h50, 1'b1, 4'b0000, 8'hA2, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 8'h51, 8'h50, 1'b1, 4'b0100, 8'h50, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 8'h51, 8'h50, 1'b1, 4'b1000, 8'hA3, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 8'h51, 8'h50, 1'b1, 4'b1100, 8'h51, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 8'h05, 8'h05, 1'b1, 4'b0001, 8'h00, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 8'hFF, 8'h01, 1'b0, 4'b0000, 8'h00, 1'b1, 1'b1};
        vecs[6]  = '{1'b1, 8'h10, 8'h77, 1'b0, 4'b0011, 8'h0F, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 8'h0F, 8'h00, 1'b0, 4'b0111, 8'hF0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 8'h01, 8'h00, 1'b0, 4'b1001, 8'h00, 1'b1, 1'b1};
        vecs[9]  = '{1'b0, 8'h3C, 8'h00, 1'b0, 4'b1110, 8'hC3, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 8'hAA, 8'h55, 1'b1, 4'b1111, 8'h00, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 8'hF0, 8'h3C, 1'b0, 4'b0101, 8'hFC, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 8'hF0, 8'h3C, 1'b0, 4'b0110, 8'hCC, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 8'h81, 8'h00, 1'b0, 4'b1011, 8'hC0, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 8'hFF, 8'h00, 1'b1, 4'b0010, 8'h00, 1'b1, 1'b1};

        rst_n = 1'b0;
        idle_inputs();
        req0_a = '0; req0_b = '0; req0_cin = 1'b0; req0_sel = '0;
        req1_a = '0; req1_b = '0; req1_cin = 1'b0; req1_sel = '0;
        apply_reset();

        // Contention: both held valid, grants alternate 0,1,0,1 every 3 cycles.
        m0 = model_alu(8'h20, 8'h03, 1'b0, 4'b0000);
        m1 = model_alu(8'h20, 8'h03, 1'b1, 4'b0001);
        for (int c = 0; c < 12; c++) begin
            next_drive();
            set_req(1'b0, 8'h20, 8'h03, 1'b0, 4'b0000);
            set_req(1'b1, 8'h20, 8'h03, 1'b1, 4'b0001);
            next_sample();
            check($sformatf("cont_ready_c%0d", c), 32'({req1_ready, req0_ready}),
                  32'((c % 3 != 0) ? 2'b00 : (((c / 3) % 2 == 0) ? 2'b01 : 2'b10)));
            check($sformatf("cont_rspv_c%0d", c), 32'({rsp1_valid, rsp0_valid}),
                  32'((c % 3 != 2) ? 2'b00 : (((c / 3) % 2 == 0) ? 2'b01 : 2'b10)));
            if (c % 3 == 2) begin
                check($sformatf("cont_data_c%0d", c), 32'({rsp_cout, rsp_z, rsp_d}),
                      32'(((c / 3) % 2 == 0) ? m0 : m1));
            end
        end
        next_drive();
        idle_inputs();

        // Busy gating: req1 raised during EXEC/RESP of a req0 operation.
        m0 = model_alu(8'h40, 8'h02, 1'b0, 4'b0000);
        m1 = model_alu(8'h0F, 8'h3C, 1'b0, 4'b0100);
        next_drive();
        set_req(1'b0, 8'h40, 8'h02, 1'b0, 4'b0000);
        next_sample();
        check("gate_ready0", 32'(req0_ready), 32'(1));
        next_drive();
        idle_inputs();
        set_req(1'b1, 8'h0F, 8'h3C, 1'b0, 4'b0100);
        next_sample();
        check("gate_exec", 32'({busy, req1_ready}), 32'(2'b10));
        next_drive();
        next_sample();
        check("gate_resp", 32'({busy, req1_ready, rsp0_valid}), 32'(3'b101));
        check("gate_resp_d", 32'(rsp_d), 32'(m0[7:0]));
        next_drive();
        next_sample();
        check("gate_idle", 32'({busy, req1_ready}), 32'(2'b01));
        check("gate_hold1", 32'(rsp_d), 32'(m0[7:0]));
        next_drive();
        idle_inputs();
        next_sample();
        check("gate_hold2", 32'({busy, rsp_d}), 32'({1'b1, m0[7:0]}));
        next_drive();
        next_sample();
        check("gate_rsp1", 32'({rsp1_valid, rsp0_valid}), 32'(2'b10));
        check("gate_d1", 32'({rsp_cout, rsp_z, rsp_d}), 32'(m1));

        // Vector table, issued back to back: responses must be 3 cycles apart.
        prev_cyc = 0;
        for (int i = 0; i < 15; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].cin,
                  vecs[i].sel, {vecs[i].cout, vecs[i].z, vecs[i].d});
            if (i > 0) check($sformatf("vec%0d_spacing", i), 32'(rsp_cyc - prev_cyc), 32'(3));
            prev_cyc = rsp_cyc;
        end

        // Reset during EXEC: operation dropped, then first tie goes to req0.
        next_drive();
        set_req(1'b0, 8'h12, 8'h34, 1'b0, 4'b0000);
        next_sample();
        check("rstmid_ready0", 32'(req0_ready), 32'(1));
        next_drive();
        idle_inputs();
        rst_n = 1'b0;
        next_sample();
        check_reset_outs("rstmid");
        next_drive();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            next_sample();
            check($sformatf("rstmid_quiet%0d", c), 32'({busy, rsp1_valid, rsp0_valid, rsp_d}), 32'(0));
            next_drive();
        end
        set_req(1'b0, 8'h01, 8'h01, 1'b0, 4'b0000);
        set_req(1'b1, 8'h02, 8'h02, 1'b0, 4'b0000);
        next_sample();
        check("rstmid_tie", 32'({req1_ready, req0_ready}), 32'(2'b01));
        next_drive();
        idle_inputs();
        next_drive();
        next_sample();
        check("rstmid_tie_rsp", 32'({rsp1_valid, rsp0_valid, rsp_d}), 32'({2'b01, 8'h02}));

        // Counters: five req0 operations.
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            do_op($sformatf("cnt_op%0d", i), 1'b0, 8'(i), 8'h01, 1'b0, 4'b0000,
                  {1'b0, 1'b0, 8'(i + 1)});
            next_drive();
            next_sample();
            check($sformatf("cnt0_after%0d", i + 1), 32'(op_cnt0), 32'(exp_cnt(i + 1)));
            check($sformatf("cnt1_after%0d", i + 1), 32'(op_cnt1), 32'(0));
        end

        // Randomized traffic against the rule-level model.
        apply_reset();
        last_w = 1'b1; free_at = 0; xfer_at = -10; rsp_due = -1;
        rsp_id = 1'b0; rsp_exp = '0; last_rsp = '0;
        for (int r = 0; r < 2; r++) begin
            pend[r] = 1'b0; served[r] = 0;
        end
        for (int k = 0; k < 450; k++) begin
            next_drive();
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && $urandom_range(0, 2) == 0) begin
                    pend[r] = 1'b1;
                    pa[r] = 8'($urandom); pb[r] = 8'($urandom);
                    pc[r] = 1'($urandom); ps[r] = 4'($urandom);
                end
            end
            req0_valid = pend[0]; req0_a = pa[0]; req0_b = pb[0]; req0_cin = pc[0]; req0_sel = ps[0];
            req1_valid = pend[1]; req1_a = pa[1]; req1_b = pb[1]; req1_cin = pc[1]; req1_sel = ps[1];
            next_sample();

            do_x = (k >= free_at) && (pend[0] || pend[1]);
            ew   = (pend[0] && pend[1]) ? ~last_w : pend[1];
            due  = (k == rsp_due);
            if (due) last_rsp = rsp_exp;
            check($sformatf("rnd_ready_k%0d", k), 32'({req1_ready, req0_ready}),
                  32'(!do_x ? 2'b00 : (ew ? 2'b10 : 2'b01)));
            check($sformatf("rnd_busy_k%0d", k), 32'(busy), 32'((k > xfer_at) && (k < free_at)));
            check($sformatf("rnd_rspv_k%0d", k), 32'({rsp1_valid, rsp0_valid}),
                  32'(!due ? 2'b00 : (rsp_id ? 2'b10 : 2'b01)));
            check($sformatf("rnd_data_k%0d", k), 32'({rsp_cout, rsp_z, rsp_d}), 32'(last_rsp));
            check($sformatf("rnd_cnt_k%0d", k), 32'({op_cnt1, op_cnt0}),
                  32'({TB_CNT_W'(exp_cnt(served[1])), TB_CNT_W'(exp_cnt(served[0]))}));

            if (due) served[rsp_id]++;
            if (do_x) begin
                exp_v   = model_alu(pa[ew], pb[ew], pc[ew], ps[ew]);
                rsp_exp = exp_v;
                rsp_id  = ew;
                last_w  = ew;
                pend[ew] = 1'b0;
                xfer_at = k;
                free_at = k + 3;
                rsp_due = k + 2;
            end
        end
        next_drive();
        idle_inputs();
        repeat (3) next_drive();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one gate-level `alu` instance between two independent requesters. Each requester issues an operation (A, B, C_in, S) over a valid/ready handshake. The block arbitrates round-robin, registers the operands, lets the ALU settle for one cycle, captures D/C_out/z, and returns them to the winning requester as a one-cycle response pulse. It sits between the ALU datapath and the two control units that need it.

## Interface
- `CNT_W`, 16: width of per-requester operation counters (used only with `ALU_ARB_STATS_EN`).
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `req0_valid`, `req1_valid`  in  1 each  requester n has an operation pending.
- `req0_ready`, `req1_ready`  out  1 each  grant; the operation transfers when valid and ready are both high.
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  8 each  operands.
- `req0_cin`, `req1_cin`  in  1 each  carry-in.
- `req0_sel`, `req1_sel`  in  4 each  ALU select code S.
- `rsp0_valid`, `rsp1_valid`  out  1 each  one-cycle result pulse to requester n.
- `rsp_d`  out  8  captured ALU result D (shared bus, qualified by rspN_valid).
- `rsp_cout`  out  1  captured C_out.
- `rsp_z`  out  1  captured zero flag z.
- `busy`  out  1  high in EXEC and RESP.
- `op_cnt0`, `op_cnt1`  out  CNT_W each  completed-operation counters.

## Operation
- FSM states:
  - **IDLE**: ready is driven combinationally to the arbitration winner only. On a transfer, latch a/b/cin/sel and the winner id, then go to EXEC. With no valid input, stay in IDLE.
  - **EXEC**: the latched operands drive the ALU. At the end of the cycle, capture D, C_out and z into the response registers, then go to RESP.
  - **RESP**: assert `rspN_valid` for the latched id for exactly one cycle, then go to IDLE.
- Arbitration:
  - Only one requester valid: that requester wins.
  - Both valid: the requester not granted last time wins.
  - `last_grant` resets to 1, so requester 0 wins the first tie.
- Protocol rules:
  - Once valid is asserted, it and the operands stay stable until the transfer.
  - Both ready outputs are low in EXEC and RESP.
  - Responses have no backpressure.
- `rsp_d`, `rsp_cout` and `rsp_z` hold their last captured value until the next capture.
- Reset values: all ready and rsp valid outputs 0; `rsp_d` 0x00; `rsp_cout` 0; `rsp_z` 0; `busy` 0; counters 0; state IDLE; `last_grant` 1.
- Reset mid-operation: the in-flight operation is dropped and no response is produced. The first tie after reset goes to requester 0.
- Select codes are passed through unchecked.

## Timing
- Transfer in cycle T → EXEC in T+1 → rspN_valid high in T+2 → IDLE in T+3. The next transfer is possible in T+3.
- Latency from transfer to response is 2 cycles. Peak throughput is 1 operation per 3 cycles.
- A requester that keeps valid high while the other is served is granted on the next IDLE cycle. Under contention the two requesters strictly alternate.

## Configuration
- `ALU_ARB_STATS_EN` defined:
  - `op_cnt0` and `op_cnt1` increment in the RESP cycle for the served requester.
  - They saturate at 2^CNT_W−1.
- `ALU_ARB_STATS_EN` undefined:
  - No counter registers are built.
  - `op_cnt0` and `op_cnt1` are tied to 0.
  - The port list is identical in both builds.

## Structure
- Package `alu_arb_pkg`: FSM state encoding (IDLE/EXEC/RESP) and requester-id constants.
- Sub-module `alu_arb_rr`: two-input round-robin picker. Inputs are the two valids and `last_grant`; outputs are the one-hot grant and the winner id.
- The `alu` is instantiated once in the top, connected in its native port order (D, C_out, z, A, B, C_in, S).

## Test plan
- **Single request.** Release reset; req0 with A=81, B=80, cin=1, S=0000, valid for 1 cycle → req0_ready=1 in that cycle; rsp0_valid=1 exactly 2 cycles later; rsp_d/rsp_cout/rsp_z equal a standalone `alu` driven with the same inputs; rsp1_valid stays 0.
- **Select sweep.** Repeat the single request for S = 0100, 1000 and 1100 → each response matches the standalone `alu`; responses are 3 cycles apart.
- **Contention.** req0 and req1 both held valid for 4 operations → grant order 0, 1, 0, 1; transfers at cycles 0, 3, 6, 9.
- **Busy gating.** Assert req1_valid during EXEC and RESP of a req0 operation → req1_ready stays 0 until IDLE, and rsp_d holds its value until the next capture.
- **Reset mid-operation.** Pull rst_n low during EXEC → no rspN_valid pulse; all outputs read their reset values; the next tie grants requester 0.
- **Counters.** With `ALU_ARB_STATS_EN` and CNT_W=2, run 5 req0 operations → op_cnt0 reads 1, 2, 3, 3, 3 and op_cnt1 stays 0. Without the macro, both counters read 0 throughout.
